// File: rtl/rx_sequencer.sv
// Receive-path sequencer: arm, wake-up detect, guard blanking, sync search, mid-bit sampling, byte handoff.
// Optional feature: define SEQ_RETRIGGER_EN to let a wake-up edge restart the sequence at GUARD.
module rx_sequencer #(
    parameter int DIV            = 100,
    parameter int GUARD_TICKS    = 20000,
    parameter int TIMEOUT_TICKS  = 60000,
    parameter int FRAME_BITS     = 1000,
    parameter int COOLDOWN_TICKS = 1000
) (
    input  logic       clki,
    input  logic       rst,
    input  logic       arm,
    input  logic       wake_up,
    input  logic       comp_out,
    input  logic       data_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       data_clk_enb,
    output logic       bit_tick,
    output logic       frame_done,
    output logic       timeout_err,
    output logic       overrun,
    output logic [2:0] state
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARMED    = 3'd1;
    localparam logic [2:0] S_GUARD    = 3'd2;
    localparam logic [2:0] S_SEARCH   = 3'd3;
    localparam logic [2:0] S_RECEIVE  = 3'd4;
    localparam logic [2:0] S_COOLDOWN = 3'd5;

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    logic [2:0]       wake_sync_q, comp_sync_q;
    logic             wake_edge, comp_edge, comp_lvl;
    logic [2:0]       state_q, state_d;
    logic [19:0]      tmr_q, tmr_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_done_q, byte_done_d;
    logic             tick_q, tick_d;
    logic             fdone_q, fdone_d;
    logic             tout_q, tout_d;
    logic             ovr_q, ovr_d;
    logic             dv_q, dv_d;
    logic [7:0]       dout_q, dout_d;
    logic             enb_q;
    logic             guard_entry;

    assign wake_edge = (wake_sync_q[2:1] == 2'b01);
    assign comp_edge = (comp_sync_q[2:1] == 2'b01);
    assign comp_lvl  = comp_sync_q[1];

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_done_d = 1'b0;
        tick_d      = 1'b0;
        fdone_d     = 1'b0;
        tout_d      = 1'b0;
        ovr_d       = ovr_q;
        dv_d        = dv_q;
        dout_d      = dout_q;
        guard_entry = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (wake_edge) begin
                    state_d     = S_GUARD;
                    tmr_d       = '0;
                    guard_entry = 1'b1;
                end
            end
            S_GUARD: begin
                tmr_d = tmr_q + 20'd1;
                if (tmr_q == 20'(GUARD_TICKS - 1)) state_d = S_SEARCH;
            end
            S_SEARCH: begin
                tmr_d = tmr_q + 20'd1;
                // A sync edge on the very last search cycle still counts as found.
                if (comp_edge) begin
                    state_d = S_RECEIVE;
                    div_d   = '0;
                    bit_d   = '0;
                end else if (tmr_q == 20'(TIMEOUT_TICKS - 1)) begin
                    tout_d  = 1'b1;
                    state_d = S_COOLDOWN;
                    tmr_d   = '0;
                end
            end
            S_RECEIVE: begin
                div_d = (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + DIV_W'(1);
                if (div_q == DIV_W'(DIV / 2 - 1)) begin
                    tick_d  = 1'b1;
                    shift_d = {shift_q[6:0], comp_lvl};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q[2:0] == 3'd7) byte_done_d = 1'b1;
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        fdone_d = 1'b1;
                        state_d = S_COOLDOWN;
                        tmr_d   = '0;
                    end
                end
            end
            S_COOLDOWN: begin
                if (tmr_q == 20'(COOLDOWN_TICKS - 1)) state_d = arm ? S_ARMED : S_IDLE;
                else tmr_d = tmr_q + 20'd1;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SEQ_RETRIGGER_EN
        if (wake_edge && (state_q >= S_GUARD) && (state_q <= S_COOLDOWN)) begin
            state_d     = S_GUARD;
            tmr_d       = '0;
            div_d       = '0;
            bit_d       = '0;
            shift_d     = '0;
            byte_done_d = 1'b0;
            tick_d      = 1'b0;
            fdone_d     = 1'b0;
            tout_d      = 1'b0;
            guard_entry = 1'b1;
        end
`endif

        if ((state_q != S_IDLE) && !arm) begin
            state_d     = S_IDLE;
            byte_done_d = 1'b0;
            tick_d      = 1'b0;
            fdone_d     = 1'b0;
            tout_d      = 1'b0;
            guard_entry = 1'b0;
        end

        if (guard_entry) ovr_d = 1'b0;

        // Handoff runs one cycle after the completing tick, independent of FSM state.
        if (byte_done_q) begin
            if (!dv_q || data_ready) begin
                dout_d = shift_q;
                dv_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (dv_q && data_ready) begin
            dv_d = 1'b0;
        end
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            wake_sync_q <= '0;
            comp_sync_q <= '0;
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            tick_q      <= 1'b0;
            fdone_q     <= 1'b0;
            tout_q      <= 1'b0;
            ovr_q       <= 1'b0;
            dv_q        <= 1'b0;
            dout_q      <= '0;
            enb_q       <= 1'b0;
        end else begin
            wake_sync_q <= {wake_sync_q[1:0], wake_up};
            comp_sync_q <= {comp_sync_q[1:0], comp_out};
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            tick_q      <= tick_d;
            fdone_q     <= fdone_d;
            tout_q      <= tout_d;
            ovr_q       <= ovr_d;
            dv_q        <= dv_d;
            dout_q      <= dout_d;
            enb_q       <= (state_d == S_RECEIVE);
        end
    end

    assign data_out     = dout_q;
    assign data_valid   = dv_q;
    assign data_clk_enb = enb_q;
    assign bit_tick     = tick_q;
    assign frame_done   = fdone_q;
    assign timeout_err  = tout_q;
    assign overrun      = ovr_q;
    assign state        = state_q;
endmodule
